fib_sched: RTL and testbench

Two-requester scheduler that shares one iterative Fibonacci engine. Each requester posts a step count under a req/ack handshake. A round-robin arbiter grants one job at a time and sequences the engine through load, iterate and respond. The result returns on a shared response bus tagged with the requester id. The block sits between client logic and the Fibonacci datapath, so several clients can share one adder.

---
 rtl/fib_pkg.sv | 12 +
 rtl/fib_core.sv | 70 +++++++
 rtl/fib_sched.sv | 121 ++++++++++++
 tb/tb_fib_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared FSM encodings and default widths for the Fibonacci scheduler.
package fib_pkg;

    localparam int FIB_N_DEF  = 8;
    localparam int FIB_SW_DEF = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/fib_core.sv
// Iterative Fibonacci engine: (a,b) <- (b,a+b) while the step counter is non-zero.
// Optional sticky overflow tracking under `FIB_SCHED_OVF_EN.
module fib_core
    import fib_pkg::*;
#(
    parameter int N  = FIB_N_DEF,
    parameter int SW = FIB_SW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [SW-1:0] i_steps,
    output logic          o_zero,
    output logic [N-1:0]  o_a,
    output logic          o_ovf
);

    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [SW-1:0] r_cnt;

`ifdef FIB_SCHED_OVF_EN
    logic [N:0] w_sum;
    logic       r_ovf_a;
    logic       r_ovf_b;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // ovf_a lags ovf_b by one iteration so it tracks the value held in a.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
        end else if (i_load) begin
            r_ovf_a <= 1'b0;
            r_ovf_b <= 1'b0;
        end else if (r_cnt != '0) begin
            r_ovf_a <= r_ovf_b;
            r_ovf_b <= r_ovf_b | w_sum[N];
        end
    end

    assign o_ovf = r_ovf_a;
`else
    logic [N-1:0] w_sum;

    assign w_sum = r_a + r_b;
    assign o_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= '0;
            r_b   <= N'(1);
            r_cnt <= i_steps;
        end else if (r_cnt != '0) begin
            r_a   <= r_b;
            r_b   <= w_sum[N-1:0];
            r_cnt <= r_cnt - SW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_a    = r_a;

endmodule

// File: rtl/fib_sched.sv
// Two-requester round-robin scheduler sharing one fib_core engine.
// Optional overflow reporting enabled by defining FIB_SCHED_OVF_EN.
module fib_sched
    import fib_pkg::*;
#(
    parameter int N  = FIB_N_DEF,
    parameter int SW = FIB_SW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [SW-1:0] steps0,
    input  logic [SW-1:0] steps1,
    output logic          ack0,
    output logic          ack1,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [N-1:0]  rsp_data,
    output logic          rsp_ovf,
    output logic          busy
);

    logic [1:0]    r_state;
    logic          r_id;
    logic [SW-1:0] r_steps;
    logic          r_last;
    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [N-1:0]  r_rsp_data;
    logic          r_rsp_ovf;

    logic          w_grant_id;
    logic          w_load;
    logic          w_zero;
    logic [N-1:0]  w_a;
    logic          w_ovf;
    logic          w_done;

    // On a tie the requester not served last wins; a sole requester always wins.
    always_comb begin
        w_grant_id = 1'b0;
        if (req0 && req1) begin
            w_grant_id = ~r_last;
        end else begin
            w_grant_id = req1;
        end
    end

    assign w_load = (r_state == ST_LOAD);
    assign w_done = (r_state == ST_RUN) && w_zero;

    fib_core #(
        .N  (N),
        .SW (SW)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_steps (r_steps),
        .o_zero  (w_zero),
        .o_a     (w_a),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_id    <= 1'b0;
            r_steps <= '0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_state <= ST_LOAD;
                        r_id    <= w_grant_id;
                        r_steps <= w_grant_id ? steps1 : steps0;
                    end
                end
                ST_LOAD: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_zero) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_last  <= r_id;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Response is captured on the last RUN cycle so it is visible during RESP and then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_ovf   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= w_a;
                r_rsp_ovf  <= w_ovf;
            end
        end
    end

    assign ack0      = w_load && !r_id;
    assign ack1      = w_load && r_id;
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_fib_sched.sv
// Self-checking bench for fib_sched: cycle-by-cycle comparison against a job-timeline model.
module tb_fib_sched;

    localparam int N  = 8;
    localparam int SW = 5;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          req0   = 1'b0;
    logic          req1   = 1'b0;
    logic [SW-1:0] steps0 = '0;
    logic [SW-1:0] steps1 = '0;
    logic          ack0;
    logic          ack1;
    logic          rsp_valid;
    logic          rsp_id;
    logic [N-1:0]  rsp_data;
    logic          rsp_ovf;
    logic          busy;

    always #5 clk = ~clk;

    fib_sched #(
        .N  (N),
        .SW (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .steps0    (steps0),
        .steps1    (steps1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Job-timeline model: one job in flight, with its ack/response/idle cycles.
    int           t;
    int           m_ack_t;
    int           m_rsp_t;
    int           m_idle_t;
    bit           m_active;
    bit           m_id;
    bit           m_last;
    logic [N-1:0] m_data;
    bit           m_ovf;
    logic [N-1:0] h_data;
    bit           h_id;
    bit           h_ovf;

    // Requester agents.
    int            jobs [2][$];
    int            gap [2];
    bit            rq [2];
    logic [SW-1:0] st [2];
    bit            rand_gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic longint fib_exact(input int k);
        longint a = 0;
        longint b = 1;
        longint s;
        for (int i = 0; i < k; i++) begin
            s = a + b;
            a = b;
            b = s;
        end
        return a;
    endfunction

    function automatic bit exp_ovf(input longint f);
`ifdef FIB_SCHED_OVF_EN
        return f >= (longint'(1) << N);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        req0   = rq[0];
        req1   = rq[1];
        steps0 = st[0];
        steps1 = st[1];
    endtask

    task automatic model_reset();
        t        = 0;
        m_ack_t  = -100;
        m_rsp_t  = -100;
        m_idle_t = 0;
        m_active = 1'b0;
        m_last   = 1'b1;
        h_data   = '0;
        h_id     = 1'b0;
        h_ovf    = 1'b0;
        for (int r = 0; r < 2; r++) begin
            jobs[r].delete();
            gap[r] = 0;
            rq[r]  = 1'b0;
            st[r]  = '0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rq[0] = 1'b0;
        rq[1] = 1'b0;
        drive();
        #1;
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_rsp_valid", 32'(rsp_valid), 0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycle_step();
        bit           e_busy;
        bit           w;
        int           k;
        longint       f;
        @(posedge clk);
        #1;
        t++;
        if (m_active && t == m_rsp_t) begin
            h_data = m_data;
            h_id   = m_id;
            h_ovf  = m_ovf;
            m_last = m_id;
        end
        e_busy = m_active && t >= m_ack_t && t <= m_rsp_t;
        check("ack0", 32'(ack0), 32'(m_active && t == m_ack_t && !m_id));
        check("ack1", 32'(ack1), 32'(m_active && t == m_ack_t && m_id));
        check("rsp_valid", 32'(rsp_valid), 32'(m_active && t == m_rsp_t));
        check("busy", 32'(busy), 32'(e_busy));
        check("rsp_data", 32'(rsp_data), 32'(h_data));
        check("rsp_id", 32'(rsp_id), 32'(h_id));
        check("rsp_ovf", 32'(rsp_ovf), 32'(h_ovf));
        if (m_active && t == m_rsp_t) begin
            $display("rsp t=%0d id=%0d data=%0d ovf=%0d", t, rsp_id, rsp_data, rsp_ovf);
            m_active = 1'b0;
        end

        for (int r = 0; r < 2; r++) begin
            if (m_active && t == m_ack_t && m_id == 1'(r)) begin
                rq[r] = 1'b0;
                st[r] = SW'($urandom);          // steps after acceptance must be ignored
                void'(jobs[r].pop_front());
                gap[r] = rand_gap ? int'($urandom_range(0, 3)) : 0;
            end else if (!rq[r] && jobs[r].size() > 0) begin
                if (gap[r] == 0) begin
                    rq[r] = 1'b1;
                    st[r] = SW'(jobs[r][0]);
                end else begin
                    gap[r]--;
                end
            end
        end

        if (!m_active && t >= m_idle_t && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) w = ~m_last;
            else                w = rq[1];
            k        = int'(st[w]);
            f        = fib_exact(k);
            m_active = 1'b1;
            m_id     = w;
            m_data   = N'(f % (longint'(1) << N));
            m_ovf    = exp_ovf(f);
            m_ack_t  = t + 1;
            m_rsp_t  = t + k + 3;
            m_idle_t = t + k + 4;
            $display("grant t=%0d id=%0d k=%0d expect=%0d", t + 1, w, k, m_data);
        end
        drive();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle_step();
    endtask

    task automatic run_until_idle(input int maxc);
        int cnt = 0;
        while (cnt < maxc && (jobs[0].size() > 0 || jobs[1].size() > 0 ||
                              rq[0] || rq[1] || m_active || t < m_idle_t)) begin
            cycle_step();
            cnt++;
        end
        check("drain_in_budget", 32'(cnt < maxc), 1);
    endtask

    initial begin
        rand_gap = 1'b0;
        model_reset();
        #2;
        apply_reset();

        // Single job, requester 0, k=10
        jobs[0].push_back(10);
        run_until_idle(100);
        check("A_data", 32'(rsp_data), 55);
        check("A_id", 32'(rsp_id), 0);
        check("A_ovf", 32'(rsp_ovf), 0);

        // k=0 then k=1 back-to-back from requester 1
        jobs[1].push_back(0);
        jobs[1].push_back(1);
        run_until_idle(100);
        check("B_data", 32'(rsp_data), 1);
        check("B_id", 32'(rsp_id), 1);

        // Tie out of reset: requester 0 first
        apply_reset();
        jobs[0].push_back(5);
        jobs[1].push_back(6);
        run_until_idle(100);
        check("C_data", 32'(rsp_data), 8);
        check("C_id", 32'(rsp_id), 1);

        // Continuous contention alternates grants
        jobs[0] = '{4, 4, 4};
        jobs[1] = '{4, 4};
        run_until_idle(200);
        check("D_id", 32'(rsp_id), 0);

        // Overflow boundary
        jobs[0].push_back(13);
        run_until_idle(100);
        check("E13_data", 32'(rsp_data), 233);
        check("E13_ovf", 32'(rsp_ovf), 0);
        jobs[0].push_back(14);
        run_until_idle(100);
        check("E14_data", 32'(rsp_data), 121);
`ifdef FIB_SCHED_OVF_EN
        check("E14_ovf", 32'(rsp_ovf), 1);
`else
        check("E14_ovf", 32'(rsp_ovf), 0);
`endif

        // Reset mid-RUN, then a fresh tie with k=3
        jobs[0].push_back(20);
        run_cycles(8);
        check("F_busy_before_reset", 32'(busy), 1);
        apply_reset();
        jobs[0].push_back(3);
        jobs[1].push_back(3);
        run_until_idle(100);
        check("F_data", 32'(rsp_data), 2);
        check("F_id", 32'(rsp_id), 1);

        // Randomised traffic with random gaps and step scrambling
        rand_gap = 1'b1;
        for (int i = 0; i < 30; i++) begin
            jobs[0].push_back(int'($urandom_range(0, (1 << SW) - 1)));
            jobs[1].push_back(int'($urandom_range(0, (1 << SW) - 1)));
        end
        run_until_idle(5000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
